// File: rtl/comp_wide_seq.sv
`default_nettype none
// ============================================================================
// Module   : comp_wide_seq
// Purpose  : Sequential wide magnitude comparator; walks operands MSB nibble
//            first through an external 4-bit comparator, exits on first diff.
// Revision : 1.0 - initial release
// ============================================================================
module comp_wide_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic [3:0]             nib_a,
  output logic [3:0]             nib_b,
  input  logic                   cmp_gt,
  input  logic                   cmp_lt,
  input  logic                   cmp_eq,
  output logic                   busy,
  output logic                   done,
  output logic                   res_gt,
  output logic                   res_lt,
  output logic                   res_eq,
  output logic                   res_err
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [NIBBLES-1:0][3:0]   a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      err_q, err_d;
  logic                      res_gt_q, res_gt_d;
  logic                      res_lt_q, res_lt_d;
  logic                      res_eq_q, res_eq_d;
  logic                      res_err_q, res_err_d;

  logic [3:0]                sel_a, sel_b;
  logic                      code_bad;
  logic                      err_now;

  generate
    if (NIBBLES == 1) begin : g_single
      assign sel_a = a_q[0];
      assign sel_b = b_q[0];
    end else begin : g_multi
      assign sel_a = a_q[idx_q];
      assign sel_b = b_q[idx_q];
    end
  endgenerate

  // Exactly one of the three comparator flags must be set.
  assign code_bad = ~(cmp_gt ^ cmp_lt ^ cmp_eq) | (cmp_gt & cmp_lt & cmp_eq);
  assign err_now  = err_q | code_bad;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    err_d     = err_q;
    res_gt_d  = res_gt_q;
    res_lt_d  = res_lt_q;
    res_eq_d  = res_eq_q;
    res_err_d = res_err_q;
    nib_a     = 4'h0;
    nib_b     = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = IDX_W'(NIBBLES - 1);
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        nib_a = sel_a;
        nib_b = sel_b;
        err_d = err_now;
        // cmp_eq wins over a stray gt/lt flag; the code error is still recorded.
        if (!cmp_eq) begin
          res_gt_d  = cmp_gt;
          res_lt_d  = ~cmp_gt;
          res_eq_d  = 1'b0;
          res_err_d = err_now;
          state_d   = S_DONE;
        end else if (idx_q == '0) begin
          res_gt_d  = 1'b0;
          res_lt_d  = 1'b0;
          res_eq_d  = 1'b1;
          res_err_d = err_now;
          state_d   = S_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      res_gt_q  <= 1'b0;
      res_lt_q  <= 1'b0;
      res_eq_q  <= 1'b0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      res_gt_q  <= res_gt_d;
      res_lt_q  <= res_lt_d;
      res_eq_q  <= res_eq_d;
      res_err_q <= res_err_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign res_gt  = res_gt_q;
  assign res_lt  = res_lt_q;
  assign res_eq  = res_eq_q;
  assign res_err = res_err_q;

endmodule
`default_nettype wire
